// File: rtl/imem_uart_loader.sv
// Loads a program image into instruction RAM from an 8N1 UART stream while load_imem is high.
// Define LOADER_CHECKSUM_EN to add a modulo-256 byte checksum output.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int IMEM_ADDR_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_imem,
  input  logic                       uart_rxd,
  output logic                       imem_wr,
  output logic [IMEM_ADDR_WIDTH-3:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       cpu_hold,
  output logic [IMEM_ADDR_WIDTH-2:0] words_loaded,
  output logic                       frame_err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]                 checksum
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IMEM_ADDR_WIDTH-2:0] WL_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        rxd_s1, rxd_s2;
  logic        load_q, load_q2;
  logic [1:0]  idx;
  logic [31:0] word_q;

  logic        load_rise, load_fall, byte_ok, stop_bad, wr_nx;
  logic [1:0]  idx_nx;
  logic [31:0] word_nx;

  assign load_rise = load_q & ~load_q2;
  assign load_fall = ~load_q & load_q2;
  // A stop bit landing in the cycle load_imem falls still completes its byte.
  assign byte_ok   = (state == S_STOP) && (cnt == BIT_LAST) && rxd_s2 && (load_q || load_q2);
  assign stop_bad  = (state == S_STOP) && (cnt == BIT_LAST) && !rxd_s2 && load_q;
  assign cpu_hold  = load_q | (load_fall & (byte_ok | (idx != 2'd0))) | imem_wr;

  always_comb begin
    word_nx = word_q;
    if (byte_ok) word_nx[{idx, 3'b000} +: 8] = shreg;
    idx_nx = byte_ok ? idx + 2'd1 : idx;
    wr_nx  = (byte_ok && idx == 2'd3) || (load_fall && idx_nx != 2'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_s1  <= 1'b1;
      rxd_s2  <= 1'b1;
      load_q  <= 1'b0;
      load_q2 <= 1'b0;
    end else begin
      rxd_s1  <= uart_rxd;
      rxd_s2  <= rxd_s1;
      load_q  <= load_imem;
      load_q2 <= load_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (!load_q) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxd_s2) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_s2 ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rxd_s2, shreg[7:1]};
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= rxd_s2 ? S_IDLE : S_WAIT_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_HI: if (rxd_s2) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_wr      <= 1'b0;
      imem_wdata   <= '0;
      imem_addr    <= '0;
      words_loaded <= '0;
      frame_err    <= 1'b0;
      idx          <= '0;
      word_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      imem_wr <= wr_nx;
      if (wr_nx) imem_wdata <= word_nx;
      if (load_rise) begin
        imem_addr    <= '0;
        words_loaded <= '0;
        frame_err    <= 1'b0;
        idx          <= '0;
        word_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
        checksum     <= '0;
`endif
      end else begin
        // Clearing the word after each write keeps unreceived lanes of a flush at zero.
        if (wr_nx) begin
          word_q <= '0;
          idx    <= '0;
        end else begin
          word_q <= word_nx;
          idx    <= idx_nx;
        end
        if (imem_wr) begin
          imem_addr <= imem_addr + 1'b1;
          if (words_loaded != WL_MAX) words_loaded <= words_loaded + 1'b1;
        end
        if (stop_bad) frame_err <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (byte_ok) checksum <= checksum + shreg;
`endif
      end
    end
  end

endmodule
